// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute controller for the 16-bit datapath; owns PC and IR.
// Optional macro CU_SINGLE_STEP_EN adds a Step input that gates the FETCH state.
module control_unit #(
    parameter int unsigned PC_W    = 7,
    parameter int unsigned DADDR_W = 8
) (
    input  logic               clk,
    input  logic               reset,
`ifdef CU_SINGLE_STEP_EN
    input  logic               Step,
`endif
    input  logic [15:0]        InstrData,
    output logic [PC_W-1:0]    PC_Addr,
    output logic [15:0]        IR,
    output logic [DADDR_W-1:0] D_Addr,
    output logic               D_Wr,
    output logic               RF_s,
    output logic [3:0]         RF_W_Addr,
    output logic               RF_W_en,
    output logic [3:0]         RF_Ra_Addr,
    output logic [3:0]         RF_Rb_Addr,
    output logic [2:0]         ALU_s0,
    output logic               Halted,
    output logic [3:0]         StateOut
);

    typedef enum logic [3:0] {
        StInit   = 4'd0,
        StFetch  = 4'd1,
        StDecode = 4'd2,
        StNoop   = 4'd3,
        StLoadA  = 4'd4,
        StLoadB  = 4'd5,
        StStore  = 4'd6,
        StAdd    = 4'd7,
        StSub    = 4'd8,
        StHalt   = 4'd9
    } state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;
    logic            fetch_go;

`ifdef CU_SINGLE_STEP_EN
    assign fetch_go = Step;
`else
    assign fetch_go = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StInit;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        D_Addr     = '0;
        D_Wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_Addr  = 4'd0;
        RF_W_en    = 1'b0;
        RF_Ra_Addr = 4'd0;
        RF_Rb_Addr = 4'd0;
        ALU_s0     = 3'd0;
        Halted     = 1'b0;

        unique case (state_q)
            StInit: state_d = StFetch;
            StFetch: begin
                if (fetch_go) begin
                    ir_d    = InstrData;
                    pc_d    = pc_q + 1'b1;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                case (ir_q[15:12])
                    4'h1:    state_d = StStore;
                    4'h2:    state_d = StLoadA;
                    4'h3:    state_d = StAdd;
                    4'h4:    state_d = StSub;
                    4'h5:    state_d = StHalt;
                    default: state_d = StNoop;
                endcase
            end
            StNoop: state_d = StFetch;
            StStore: begin
                D_Addr     = DADDR_W'(ir_q[7:0]);
                RF_Ra_Addr = ir_q[11:8];
                D_Wr       = 1'b1;
                state_d    = StFetch;
            end
            // Address is presented a cycle early so the synchronous RAM has data in LOAD_B.
            StLoadA: begin
                D_Addr  = DADDR_W'(ir_q[11:4]);
                state_d = StLoadB;
            end
            StLoadB: begin
                D_Addr    = DADDR_W'(ir_q[11:4]);
                RF_s      = 1'b1;
                RF_W_Addr = ir_q[3:0];
                RF_W_en   = 1'b1;
                state_d   = StFetch;
            end
            StAdd, StSub: begin
                RF_Ra_Addr = ir_q[11:8];
                RF_Rb_Addr = ir_q[7:4];
                RF_W_Addr  = ir_q[3:0];
                RF_W_en    = 1'b1;
                ALU_s0     = (state_q == StAdd) ? 3'd1 : 3'd2;
                state_d    = StFetch;
            end
            StHalt: Halted = 1'b1;
            default: state_d = StInit;
        endcase
    end

    assign PC_Addr  = pc_q;
    assign IR       = ir_q;
    assign StateOut = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Randomised bench for control_unit: an instruction-level model expands each ROM word
// into its expected per-cycle output snapshots, compared on every falling edge.
module tb_control_unit;

    typedef struct packed {
        logic [6:0]  pc;
        logic [15:0] ir;
        logic [7:0]  daddr;
        logic        dwr;
        logic        rfs;
        logic [3:0]  waddr;
        logic        wen;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [2:0]  alu;
        logic        halted;
        logic [3:0]  st;
    } snap_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] InstrData;
    logic [6:0]  PC_Addr;
    logic [15:0] IR;
    logic [7:0]  D_Addr;
    logic        D_Wr, RF_s, RF_W_en, Halted;
    logic [3:0]  RF_W_Addr, RF_Ra_Addr, RF_Rb_Addr, StateOut;
    logic [2:0]  ALU_s0;
`ifdef CU_SINGLE_STEP_EN
    logic        Step = 1'b1;
`endif

    logic [15:0] rom [128];
    snap_t       dut_s;
    snap_t       q[$];
    logic [6:0]  m_pc;
    logic [15:0] m_ir;
    logic        m_halt;
    logic        saw_wrap;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign InstrData = rom[PC_Addr];
    assign dut_s = {PC_Addr, IR, D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_en,
                    RF_Ra_Addr, RF_Rb_Addr, ALU_s0, Halted, StateOut};

    control_unit #(.PC_W(7), .DADDR_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef CU_SINGLE_STEP_EN
        .Step       (Step),
`endif
        .InstrData  (InstrData),
        .PC_Addr    (PC_Addr),
        .IR         (IR),
        .D_Addr     (D_Addr),
        .D_Wr       (D_Wr),
        .RF_s       (RF_s),
        .RF_W_Addr  (RF_W_Addr),
        .RF_W_en    (RF_W_en),
        .RF_Ra_Addr (RF_Ra_Addr),
        .RF_Rb_Addr (RF_Rb_Addr),
        .ALU_s0     (ALU_s0),
        .Halted     (Halted),
        .StateOut   (StateOut)
    );

    // ---------------- reference model ----------------
    function automatic snap_t mk(input logic [3:0] st);
        snap_t s;
        s    = '0;
        s.pc = m_pc;
        s.ir = m_ir;
        s.st = st;
        return s;
    endfunction

    task automatic model_reset();
        q.delete();
        m_pc   = 7'd0;
        m_ir   = 16'd0;
        m_halt = 1'b0;
        q.push_back(mk(4'd0));
    endtask

    // Append the cycles of the next instruction (or one more HALT cycle).
    task automatic model_expand();
        snap_t s, b;
        if (m_halt) begin
            s = mk(4'd9);
            s.halted = 1'b1;
            q.push_back(s);
            return;
        end
        q.push_back(mk(4'd1));
        m_ir = rom[m_pc];
        m_pc = m_pc + 7'd1;
        q.push_back(mk(4'd2));
        case (m_ir[15:12])
            4'h1: begin
                s = mk(4'd6);
                s.daddr = m_ir[7:0];
                s.ra = m_ir[11:8];
                s.dwr = 1'b1;
                q.push_back(s);
            end
            4'h2: begin
                s = mk(4'd4);
                s.daddr = m_ir[11:4];
                b = mk(4'd5);
                b.daddr = m_ir[11:4];
                b.rfs = 1'b1;
                b.waddr = m_ir[3:0];
                b.wen = 1'b1;
                q.push_back(s);
                q.push_back(b);
            end
            4'h3, 4'h4: begin
                s = mk((m_ir[15:12] == 4'h3) ? 4'd7 : 4'd8);
                s.ra = m_ir[11:8];
                s.rb = m_ir[7:4];
                s.waddr = m_ir[3:0];
                s.wen = 1'b1;
                s.alu = (m_ir[15:12] == 4'h3) ? 3'd1 : 3'd2;
                q.push_back(s);
            end
            4'h5: begin
                m_halt = 1'b1;
                s = mk(4'd9);
                s.halted = 1'b1;
                q.push_back(s);
            end
            default: q.push_back(mk(4'd3));
        endcase
    endtask

    // ---------------- helpers ----------------
    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // Compare n consecutive cycles against the model, starting at the current falling edge.
    task automatic run_model(input string name, input int n);
        snap_t exp_s;
        logic [6:0] prev_pc;
        prev_pc = PC_Addr;
        for (int i = 0; i < n; i++) begin
            if (q.size() == 0) model_expand();
            exp_s = q.pop_front();
            checks++;
            if (dut_s !== exp_s) begin
                errors++;
                $display("FAIL %s cycle %0d: got %h expected %h", name, i, dut_s, exp_s);
            end
            checks++;
            if ((D_Wr & RF_W_en) !== 1'b0) begin
                errors++;
                $display("FAIL %s strobe_overlap cycle %0d: got D_Wr=%b RF_W_en=%b required not both",
                         name, i, D_Wr, RF_W_en);
            end
            if (prev_pc == 7'd127 && PC_Addr == 7'd0) saw_wrap = 1'b1;
            prev_pc = PC_Addr;
            @(negedge clk);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_rom();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (dut_s !== '0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: got %h required 0", i, dut_s);
            end
        end
        reset = 1'b0;
        model_reset();
        run_model("reset_seq", 3);
    endtask

    task automatic test_directed();
        clear_rom();
        rom[0] = 16'h21A3;
        rom[1] = 16'h3345;
        rom[2] = 16'h4536;
        rom[3] = 16'h162B;
        rom[4] = 16'hF123;
        rom[5] = 16'h5000;
        apply_reset();
        run_model("directed", 45);
        checks++;
        if (PC_Addr !== 7'd6 || Halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_freeze: got pc=%0d halted=%b required pc=6 halted=1", PC_Addr, Halted);
        end
        // Reset out of HALT.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (dut_s !== '0) begin
            errors++;
            $display("FAIL reset_from_halt: got %h required 0", dut_s);
        end
        model_reset();
        run_model("after_halt_reset", 8);
    endtask

    task automatic test_reset_mid_load();
        clear_rom();
        rom[0] = 16'h21A3;
        apply_reset();
        run_model("pre_load", 3);
        checks++;
        if (StateOut !== 4'd4) begin
            errors++;
            $display("FAIL mid_load_state: got %0d required 4", StateOut);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (dut_s !== '0) begin
            errors++;
            $display("FAIL reset_mid_load: got %h required 0", dut_s);
        end
        model_reset();
        run_model("post_mid_reset", 10);
    endtask

    task automatic test_random();
        logic [3:0] op;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 128; i++) begin
                op = 4'($urandom_range(0, 15));
                if (op == 4'h5 && $urandom_range(0, 9) != 0) op = 4'h3;
                rom[i] = {op, 12'($urandom)};
            end
            apply_reset();
            run_model("random", 300);
        end
    endtask

    task automatic test_pc_wrap();
        clear_rom();
        apply_reset();
        saw_wrap = 1'b0;
        run_model("pc_wrap", 1 + 128 * 3 + 6);
        checks++;
        if (saw_wrap !== 1'b1) begin
            errors++;
            $display("FAIL pc_wrap: got wrap=%b required 1", saw_wrap);
        end
    endtask

`ifdef CU_SINGLE_STEP_EN
    task automatic test_single_step();
        clear_rom();
        Step = 1'b0;
        apply_reset();
        @(negedge clk);
        for (int i = 0; i < 30; i++) begin
            checks++;
            if (StateOut !== 4'd1 || PC_Addr !== 7'd0) begin
                errors++;
                $display("FAIL step_hold cycle %0d: got st=%0d pc=%0d required st=1 pc=0",
                         i, StateOut, PC_Addr);
            end
            @(negedge clk);
        end
        Step = 1'b1;
        @(negedge clk);
        checks++;
        if (StateOut !== 4'd2 || PC_Addr !== 7'd1) begin
            errors++;
            $display("FAIL step_release: got st=%0d pc=%0d required st=2 pc=1", StateOut, PC_Addr);
        end
    endtask
`endif

    initial begin
        saw_wrap = 1'b0;
        clear_rom();
        test_reset();
        test_directed();
        test_reset_mid_load();
        test_random();
        test_pc_wrap();
`ifdef CU_SINGLE_STEP_EN
        test_single_step();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
